// File: rtl/plru_pkg.sv
// rtl/plru_pkg.sv - shared types and tree pseudo-LRU helper functions
package plru_pkg;

  // Largest supported tree: 8 ways, 3 levels, 7 node bits.
  localparam int MAX_WAYS   = 8;
  localparam int MAX_LEVELS = 3;
  localparam int MAX_WIDTH  = MAX_WAYS - 1;

  // Way numbers and tree bits are carried at full width; users slice them down.
  typedef logic [MAX_LEVELS-1:0] way_t;
  typedef logic [MAX_WIDTH-1:0]  tree_t;

  // A binary tree over WAYS leaves has WAYS-1 internal nodes.
  function automatic int plru_width(int ways);
    return ways - 1;
  endfunction

  // Walk from the root following the node bits (0 = left child, 1 = right child).
  function automatic way_t plru_victim(tree_t bits, int levels);
    way_t       w;
    logic [3:0] node;
    logic       b;
    w    = '0;
    node = '0;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        b    = bits[node[2:0]];
        w    = {w[MAX_LEVELS-2:0], b};
        node = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
      end
    end
    return w;
  endfunction

  // Point every node on the way's path away from that way; other nodes keep their value.
  function automatic tree_t plru_update(tree_t bits, way_t way, int levels);
    tree_t      nb;
    logic [3:0] node;
    logic       dir;
    int         sel;
    nb   = bits;
    node = '0;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (l < levels) begin
        sel            = levels - 1 - l;
        dir            = way[sel[1:0]];
        nb[node[2:0]]  = ~dir;
        node           = {node[2:0], 1'b0} + 4'd1 + {3'b000, dir};
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/plru_ctrl_if.sv
// rtl/plru_ctrl_if.sv - lookup/update bus between the cache pipeline and plru_ctrl
interface plru_ctrl_if
  import plru_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int WAYS    = 4
);

  localparam int LW    = $clog2(WAYS);
  localparam int WIDTH = plru_width(WAYS);

  logic               req_valid;
  logic [S_INDEX-1:0] req_set;
  logic               req_ready;
  logic               stall;
  logic               lru_valid;
  logic [LW-1:0]      victim_way;
  logic [WIDTH-1:0]   lru_bits;
  logic               upd_valid;
  logic [LW-1:0]      upd_way;

  // Pipeline side: issues lookups, holds the stage, reports hits/fills.
  modport master (
    output req_valid, req_set, stall, upd_valid, upd_way,
    input  req_ready, lru_valid, victim_way, lru_bits
  );

  // Controller side.
  modport slave (
    input  req_valid, req_set, stall, upd_valid, upd_way,
    output req_ready, lru_valid, victim_way, lru_bits
  );

endinterface

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - combinational victim select and tree update for one set
module plru_tree
  import plru_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int LW    = $clog2(WAYS),
  localparam int WIDTH = plru_width(WAYS)
) (
  input  logic [WIDTH-1:0] bits_i,
  input  logic [LW-1:0]    way_i,
  output logic [LW-1:0]    victim_o,
  output logic [WIDTH-1:0] next_o
);

  tree_t bits_full;
  way_t  way_full;
  tree_t next_full;
  way_t  vic_full;
  logic  unused_tree;

  // Widen the set's bits and the accessed way to the package's full-size types.
  always_comb begin
    bits_full            = '0;
    way_full             = '0;
    bits_full[WIDTH-1:0] = bits_i;
    way_full[LW-1:0]     = way_i;
  end

  assign vic_full  = plru_victim(bits_full, LW);
  assign next_full = plru_update(bits_full, way_full, LW);

  assign victim_o  = vic_full[LW-1:0];
  assign next_o    = next_full[WIDTH-1:0];

  // Upper bits are always zero for trees smaller than the maximum.
  assign unused_tree = ^{vic_full, next_full};

endmodule

// File: rtl/plru_ctrl.sv
// rtl/plru_ctrl.sv - tree pseudo-LRU controller driving a dual-port LRU array
module plru_ctrl
  import plru_pkg::*;
#(
  parameter  int S_INDEX = 4,
  parameter  int WAYS    = 4,
  parameter  int WIDTH   = plru_width(WAYS),
  localparam int LW      = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  plru_ctrl_if.slave         bus,
  // Array read port
  output logic               lru_csb0,
  output logic               lru_web0,
  output logic [S_INDEX-1:0] lru_addr0,
  output logic [WIDTH-1:0]   lru_din0,
  input  logic [WIDTH-1:0]   lru_dout0,
  // Array write port
  output logic               lru_csb1,
  output logic               lru_web1,
  output logic [S_INDEX-1:0] lru_addr1,
  output logic [WIDTH-1:0]   lru_din1,
  input  logic [WIDTH-1:0]   lru_dout1
);

  // Lookup stage
  logic               s1_valid_q, s1_valid_d;
  logic [S_INDEX-1:0] s1_set_q,   s1_set_d;

  // One-deep forward of the write issued last cycle (not yet in the array)
  logic               fwd_valid_q, fwd_valid_d;
  logic [S_INDEX-1:0] fwd_set_q,   fwd_set_d;
  logic [WIDTH-1:0]   fwd_bits_q,  fwd_bits_d;

  logic               req_fire;
  logic               wr_en;
  logic               fwd_hit;
  logic [WIDTH-1:0]   eff_bits;
  logic [WIDTH-1:0]   next_bits;
  logic [LW-1:0]      victim;
  logic               unused_dout1;

  assign req_fire = bus.req_valid && !bus.stall;
  assign wr_en    = s1_valid_q && bus.upd_valid;

  // The array still shows the old bits for one cycle after a write; cover that window.
  assign fwd_hit  = fwd_valid_q && (fwd_set_q == s1_set_q);
  assign eff_bits = fwd_hit ? fwd_bits_q : lru_dout0;

  // Victim and updated bits both derive from the same effective tree state.
  plru_tree #(
    .WAYS (WAYS)
  ) u_tree (
    .bits_i   (eff_bits),
    .way_i    (bus.upd_way),
    .victim_o (victim),
    .next_o   (next_bits)
  );

  // Next state: stage loads only when not stalled; forward tracks the write just issued.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_set_d    = s1_set_q;
    fwd_valid_d = wr_en;
    fwd_set_d   = fwd_set_q;
    fwd_bits_d  = fwd_bits_q;
    if (!bus.stall) begin
      s1_valid_d = bus.req_valid;
      s1_set_d   = bus.req_set;
    end
    if (wr_en) begin
      fwd_set_d  = s1_set_q;
      fwd_bits_d = next_bits;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_set_q    <= '0;
      fwd_valid_q <= 1'b0;
      fwd_set_q   <= '0;
      fwd_bits_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_set_q    <= s1_set_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_set_q   <= fwd_set_d;
      fwd_bits_q  <= fwd_bits_d;
    end
  end

  // Pipeline-facing outputs.
  assign bus.req_ready  = !bus.stall;
  assign bus.lru_valid  = s1_valid_q;
  assign bus.victim_way = s1_valid_q ? victim : '0;
  assign bus.lru_bits   = eff_bits;

  // Read port: the held address keeps dout tracking the stalled set.
  assign lru_csb0  = rst || !req_fire;
  assign lru_web0  = 1'b1;
  assign lru_addr0 = bus.req_set;
  assign lru_din0  = '0;

  // Write port stays selected; web high on idle cycles cancels the registered write.
  assign lru_csb1  = 1'b0;
  assign lru_web1  = rst || !wr_en;
  assign lru_addr1 = s1_set_q;
  assign lru_din1  = next_bits;

  assign unused_dout1 = ^lru_dout1;

endmodule

// File: tb/tb_plru_ctrl.sv
// tb/tb_plru_ctrl.sv - directed vector bench for plru_ctrl with a dual-port array model
module tb_plru_ctrl;

  logic       clk;
  logic       rst;
  logic       lru_csb0, lru_web0, lru_csb1, lru_web1;
  logic [3:0] lru_addr0, lru_addr1;
  logic [2:0] lru_din0, lru_din1, lru_dout0, lru_dout1;

  plru_ctrl_if #(.S_INDEX(4), .WAYS(4)) bus ();

  plru_ctrl #(.S_INDEX(4), .WAYS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .lru_csb0  (lru_csb0),
    .lru_web0  (lru_web0),
    .lru_addr0 (lru_addr0),
    .lru_din0  (lru_din0),
    .lru_dout0 (lru_dout0),
    .lru_csb1  (lru_csb1),
    .lru_web1  (lru_web1),
    .lru_addr1 (lru_addr1),
    .lru_din1  (lru_din1),
    .lru_dout1 (lru_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: registered commands, combinational dout, write commits one cycle after issue.
  logic [2:0] mem [16];
  logic [3:0] a0_r, a1_r;
  logic [2:0] d1_r;
  logic       w1_r;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 3'b000;
      a0_r <= 4'd0;
      a1_r <= 4'd0;
      d1_r <= 3'b000;
      w1_r <= 1'b1;
    end else begin
      if (!lru_csb0) a0_r <= lru_addr0;
      if (!w1_r) mem[a1_r] <= d1_r;
      if (!lru_csb1) begin
        a1_r <= lru_addr1;
        d1_r <= lru_din1;
        w1_r <= lru_web1;
      end
    end
  end

  assign lru_dout0 = mem[a0_r];
  assign lru_dout1 = mem[a1_r];

  typedef struct {
    logic       rst, rv;
    logic [3:0] rs;
    logic       st, uv;
    logic [1:0] uw;
    logic       chk, ev;
    logic [2:0] eb;
    logic [1:0] evic;
    logic       ew;
    logic [2:0] ed;
    logic [3:0] ea;
    logic       cm;
    logic [3:0] ms;
    logic [2:0] mv;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(bit rst_v, bit rv, int rs, bit st, bit uv, int uw,
                              bit chk, bit ev, int eb, int evic,
                              bit ew, int ed, int ea, bit cm, int ms, int mv);
    vec_t v;
    v.rst = rst_v; v.rv = rv; v.rs = rs[3:0]; v.st = st; v.uv = uv; v.uw = uw[1:0];
    v.chk = chk; v.ev = ev; v.eb = eb[2:0]; v.evic = evic[1:0];
    v.ew = ew; v.ed = ed[2:0]; v.ea = ea[3:0];
    v.cm = cm; v.ms = ms[3:0]; v.mv = mv[2:0];
    return v;
  endfunction

  task automatic check(string name, int row, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(bit rst_v, bit rv, logic [3:0] rs, bit st, bit uv, logic [1:0] uw);
    rst           = rst_v;
    bus.req_valid = rv;
    bus.req_set   = rs;
    bus.stall     = st;
    bus.upd_valid = uv;
    bus.upd_way   = uw;
  endtask

  initial begin
    drive(1, 0, 4'd0, 0, 0, 2'd0);

    //                rst rv set st uv uw  chk ev bits  vic  web din   addr  cm ms mv
    // reset and idle
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    // lookup set 3 after reset
    vecs.push_back(mk(0, 1, 3, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 3'b000, 0,  1, 0,     0,    0, 0, 0));
    // set 3: update way 0, later lookup
    vecs.push_back(mk(0, 1, 3, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  1, 1, 3'b000, 0,  0, 3'b011, 3,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 3'b011, 2,  1, 0,     0,    0, 0, 0));
    // set 7: back-to-back, forwarded result
    vecs.push_back(mk(0, 1, 7, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 7, 0, 1, 2,  1, 1, 3'b000, 0,  0, 3'b100, 7,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 3'b100, 0,  1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    1, 7, 3'b100));
    // set 1: stalled stage absorbs two updates, blocked request to set 5
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 1, 1, 2,  1, 1, 3'b000, 0,  0, 3'b100, 1,   0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 1, 1, 1,  1, 1, 3'b100, 0,  0, 3'b101, 1,   0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0,  1, 1, 3'b101, 3,  1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 3'b101, 3,  1, 0,     0,    1, 1, 3'b101));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    // set 9: ways 0..3 in successive lookups
    vecs.push_back(mk(0, 1, 9, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 9, 0, 1, 0,  1, 1, 3'b000, 0,  0, 3'b011, 9,   0, 0, 0));
    vecs.push_back(mk(0, 1, 9, 0, 1, 1,  1, 1, 3'b011, 2,  0, 3'b001, 9,   0, 0, 0));
    vecs.push_back(mk(0, 1, 9, 0, 1, 2,  1, 1, 3'b001, 2,  0, 3'b100, 9,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3,  1, 1, 3'b100, 0,  0, 3'b000, 9,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    1, 9, 3'b100));
    vecs.push_back(mk(0, 1, 9, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 3'b000, 0,  1, 0,     0,    0, 0, 0));
    // set 2 -> 011, then reset while valid with an update pending
    vecs.push_back(mk(0, 1, 2, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  1, 1, 3'b000, 0,  0, 3'b011, 2,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    1, 2, 3'b011));
    vecs.push_back(mk(1, 0, 0, 0, 1, 3,  1, 1, 3'b011, 2,  1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    1, 2, 3'b000));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0,  1, 0, 0,     0,   1, 0,     0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 3'b000, 0,  1, 0,     0,    0, 0, 0));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rs, vecs[i].st, vecs[i].uv, vecs[i].uw);
      #3;
      check("req_ready", i, 32'(bus.req_ready), 32'(!vecs[i].st));
      check("lru_csb0", i, 32'(lru_csb0), 32'(vecs[i].rst || !(vecs[i].rv && !vecs[i].st)));
      if (!vecs[i].rst && vecs[i].rv && !vecs[i].st)
        check("lru_addr0", i, 32'(lru_addr0), 32'(vecs[i].rs));
      check("static_ports", i, 32'({lru_web0, lru_csb1, lru_din0}), 32'(5'b10000));
      check("lru_web1", i, 32'(lru_web1), 32'(vecs[i].ew));
      if (!vecs[i].ew) begin
        check("lru_din1", i, 32'(lru_din1), 32'(vecs[i].ed));
        check("lru_addr1", i, 32'(lru_addr1), 32'(vecs[i].ea));
      end
      if (vecs[i].chk) begin
        check("lru_valid", i, 32'(bus.lru_valid), 32'(vecs[i].ev));
        check("victim_way", i, 32'(bus.victim_way), 32'(vecs[i].ev ? vecs[i].evic : 2'd0));
        if (vecs[i].ev)
          check("lru_bits", i, 32'(bus.lru_bits), 32'(vecs[i].eb));
      end
      if (vecs[i].cm)
        check("array_contents", i, 32'(mem[vecs[i].ms]), 32'(vecs[i].mv));
    end

    // Write issued on set 5, reset in the following cycle: the write must never land.
    @(posedge clk); #1; drive(0, 1, 4'd5, 0, 0, 2'd0);
    @(posedge clk); #1; drive(0, 0, 4'd0, 0, 1, 2'd0);
    #3;
    check("seq_rst_write_issued", 100, 32'({lru_web1, lru_din1}), 32'({1'b0, 3'b011}));
    @(posedge clk); #1; drive(1, 0, 4'd0, 0, 0, 2'd0);
    @(posedge clk); #1; drive(0, 1, 4'd5, 0, 0, 2'd0);
    #3;
    check("seq_rst_valid_cleared", 101, 32'(bus.lru_valid), 32'(1'b0));
    @(posedge clk); #1; drive(0, 0, 4'd0, 0, 0, 2'd0);
    #3;
    check("seq_rst_lookup_valid", 102, 32'(bus.lru_valid), 32'(1'b1));
    check("seq_rst_lookup_bits", 102, 32'(bus.lru_bits), 32'(3'b000));
    check("seq_rst_array", 102, 32'(mem[5]), 32'(3'b000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plru_ctrl.md
# plru_ctrl

Tree pseudo-LRU controller for the set-associative cache pipeline. It drives both ports of the dual-port `lru_array`:
- Port 0 reads the set's LRU bits at lookup.
- Port 1 writes back updated bits on hit or fill.

It produces the replacement victim one cycle after lookup, and forwards in-flight writes so back-to-back accesses to one set see current state.

## Interface
- `S_INDEX`, 4, set-index width; matches the array.
- `WAYS`, 4, associativity; power of two, 2..8.
- `WIDTH`, `WAYS-1`, tree-bit width; matches the array.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset. Also routed to `lru_array`.
- `req_valid` in 1: lookup request.
- `req_set` in `S_INDEX`: lookup set.
- `req_ready` out 1: `!stall`.
- `stall` in 1: holds the lookup stage and blocks new requests.
- `lru_valid` out 1: a lookup-stage entry is valid.
- `victim_way` out `$clog2(WAYS)`: replacement way for the lookup-stage set.
- `lru_bits` out `WIDTH`: effective (forwarded) tree bits of the lookup-stage set.
- `upd_valid` in 1: access to the lookup-stage set; ignored unless `lru_valid`.
- `upd_way` in `$clog2(WAYS)`: way that was hit or filled.
- `lru_csb0`, `lru_web0`, `lru_addr0` out 1/1/`S_INDEX`: array read port.
- `lru_din0` out `WIDTH`: array read port; tied 0.
- `lru_dout0` in `WIDTH`: array read port.
- `lru_csb1`, `lru_web1`, `lru_addr1`, `lru_din1` out 1/1/`S_INDEX`/`WIDTH`: array write port.
- `lru_dout1` in `WIDTH`: unused.

## Operation
- Array contract:
  - Port command is registered when `csb` is low.
  - `dout` is combinational from the registered address.
  - A write issued in cycle N is committed at the end of cycle N+1.
  - The array registers `web` only when `csb` is low.
- Port 0:
  - `lru_web0`=1 always.
  - `lru_csb0 = !(req_valid && !stall)`.
  - When `lru_csb0` is high the registered address holds, so `lru_dout0` keeps tracking the held set.
- Port 1:
  - `lru_csb1`=0 always.
  - `lru_web1 = !(lru_valid && upd_valid)`.
  - This cancels the registered write on idle cycles.
- Lookup stage:
  - `s1_valid`/`s1_set` load from `req_valid`/`req_set` when `!stall`.
  - They hold when `stall` is high.
  - `lru_valid = s1_valid`.
- Forward register:
  - `fwd_valid`, `fwd_set`, `fwd_bits` load on every issued write.
  - `fwd_valid` clears the next cycle unless another write is issued.
  - Effective bits = `fwd_bits` if `fwd_valid && fwd_set==s1_set`, else `lru_dout0`.
- Tree encoding:
  - Heap order: node i has children 2i+1 and 2i+2. Bit 0 selects the left child.
  - Victim: walk from the root following the bits.
  - Update for way w: along w's path, set each node bit to point away from w. Off-path bits are unchanged.
  - 4-way summary (b2b1b0):
    - w0: b0=1, b1=1.
    - w1: b0=1, b1=0.
    - w2: b0=0, b2=1.
    - w3: b0=0, b2=0.
- Write: `lru_addr1=s1_set`, `lru_din1=update(effective, upd_way)`.
- Stall: updates are accepted in stalled cycles. Each update uses the prior effective bits, so repeated updates compose.
- Reset:
  - `s1_valid`=0, `fwd_valid`=0, `lru_csb0`=1, `lru_web1`=1.
  - `lru_valid`=0, `victim_way`=0.
  - Array contents become 0.
  - Reset mid-operation discards a pending write.

## Timing
- Lookup accepted in cycle N → `victim_way`/`lru_bits` valid in cycle N+1 (combinational from `lru_dout0`/forward).
- Update in cycle N → write issued in cycle N, forwarded in N+1, visible from the array in N+2.
- Forwarding needs exactly one level.
- Same-set back-to-back (request in N, update in N+1 for the prior request) → cycle N+2 sees the updated bits.
- Simultaneous new request and update are both honoured.

## Structure
- `plru_pkg` holds:
  - the `way_t` typedef;
  - the `WIDTH` derivation;
  - functions `plru_victim` and `plru_update`.
- One combinational sub-module, `plru_tree` (bits in, way in → victim, next bits), shared by lookup and update.

## Test plan
- After reset, lookup set 3 → cycle+1: `lru_bits`=000, `victim_way`=0, `lru_valid`=1.
- Lookup set 3, update way 0 → `lru_din1`=011, `lru_addr1`=3, `lru_web1`=0. Later lookup set 3 → `lru_bits`=011, victim 2.
- Set 7: requests in cycles 0 and 1, update way 2 in cycle 1 → cycle 2 `lru_bits`=100 via forward, victim 0; array holds 100 by cycle 3.
- Lookup set 1, then stall 3 cycles; update way 2 in stalled cycle 1 and way 1 in cycle 2 → `lru_bits` 100 then 101, victim 3; no lookup accepted while stalled.
- Set 9: updates of ways 0, 1, 2, 3 in separate lookups → bits 011, 001, 100, 000; final victim 0.
- Set 2 holding 011, assert `rst` while `lru_valid`=1 and `upd_valid`=1 → no write commits; outputs at reset values; lookup set 2 → 000.
